// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-cycle memory-controller port between
// NREQ requesters. Whole bursts are granted round-robin, a grant is forcibly
// rotated after MAX_HOLD accesses when someone else is waiting, every grant
// change costs one dead cycle, and 1-cycle-latency read data is steered back
// to the requester that issued the read.
module mem_port_arbiter #(
  parameter int NREQ         = 2,
  parameter int addr_wid_mem = 26,
  parameter int data_wid     = 32,
  parameter int stroblen     = data_wid / 8,
  parameter int MAX_HOLD     = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [NREQ-1:0]              req,
  output logic [NREQ-1:0]              gnt,
  input  logic [NREQ*addr_wid_mem-1:0] r_addr,
  input  logic [NREQ*data_wid-1:0]     r_wdata,
  input  logic [NREQ*stroblen-1:0]     r_wstrb,
  input  logic [NREQ-1:0]              r_read,
  input  logic [NREQ-1:0]              r_write,
  output logic [NREQ-1:0]              r_rvalid,
  output logic [data_wid-1:0]          r_rdata,
  output logic [addr_wid_mem-1:0]      maddr,
  output logic [data_wid-1:0]          mdata,
  output logic [stroblen-1:0]          mwstrb,
  output logic                         mread,
  output logic                         mwrite,
  input  logic [data_wid-1:0]          sdata,
  output logic                         gclken,
  output logic                         proto_err
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_HANDOFF = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   owner, owner_nxt;
  logic [IW-1:0]   rr_ptr, rr_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic            in_grant;
  logic            own_req, own_rd, own_wr;
  logic            others_req;
  logic            hold_last;
  logic            rd_pend;
  logic [IW-1:0]   rd_id;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IW'(1);
  endfunction

  // Owner-side view of the requester bundle.
  assign in_grant   = (state == S_GRANT);
  assign own_req    = req[owner];
  assign own_rd     = r_read[owner];
  assign own_wr     = r_write[owner];
  assign others_req = |(req & ~onehot(owner));
  assign hold_last  = (hold_cnt == HOLD_LAST);

  // Round-robin search: first requester at or after rr_ptr, wrapping mod NREQ.
  always_comb begin : rr_pick
    logic [IW-1:0] cand;
    // NOTE: every variable of a combinational block gets a value before any
    // branch; otherwise paths that skip the assignment infer a latch.
    pick_valid = 1'b0;
    pick_idx   = rr_ptr;
    cand       = rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  // Next-state logic: grant on any request, leave on release or forced rotation.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    hold_nxt  = hold_cnt;
    case (state)
      S_IDLE, S_HANDOFF: begin
        if (pick_valid) begin
          state_nxt = S_GRANT;
          owner_nxt = pick_idx;
          rr_nxt    = wrap_inc(pick_idx);
          hold_nxt  = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        if (!own_req || (hold_last && others_req)) begin
          state_nxt = S_HANDOFF;
        end else if ((own_rd || own_wr) && !hold_last) begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Arbiter state and the registered one-hot grant.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= S_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= (state_nxt == S_GRANT) ? onehot(owner_nxt) : '0;
    end
  end

  // Memory port mux from the registered owner; quiet outside GRANT.
  always_comb begin
    maddr     = '0;
    mdata     = '0;
    mwstrb    = '0;
    mwrite    = 1'b0;
    mread     = 1'b0;
    proto_err = 1'b0;
    if (in_grant) begin
      maddr     = r_addr[owner*addr_wid_mem +: addr_wid_mem];
      mdata     = r_wdata[owner*data_wid +: data_wid];
      mwstrb    = r_wstrb[owner*stroblen +: stroblen];
      mwrite    = own_wr;
      mread     = own_rd & ~own_wr;
      proto_err = own_rd & own_wr;
    end
  end

  // Read-return tag: remembers who issued the read one cycle ago, so data
  // lands correctly even if the grant ended on that same edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_pend <= 1'b0;
      rd_id   <= '0;
    end else begin
      rd_pend <= mread;
      rd_id   <= owner;
    end
  end

  assign r_rvalid = rd_pend ? onehot(rd_id) : '0;
  assign r_rdata  = rd_pend ? sdata : '0;
  assign gclken   = (state != S_IDLE) | (|req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (NREQ=3). A transaction-level
// reference (current owner, dead-cycle flag, rotation pointer, hold count and
// a reference memory) predicts every output each cycle; directed phases also
// check grant order and burst lengths against hand-derived constants.
module tb_mem_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int MH = 16;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [N*AW-1:0] r_addr;
  logic [N*DW-1:0] r_wdata;
  logic [N*SW-1:0] r_wstrb;
  logic [N-1:0]    r_read, r_write;
  logic [N-1:0]    r_rvalid;
  logic [DW-1:0]   r_rdata;
  logic [AW-1:0]   maddr;
  logic [DW-1:0]   mdata;
  logic [SW-1:0]   mwstrb;
  logic            mread, mwrite;
  logic [DW-1:0]   sdata;
  logic            gclken, proto_err;

  mem_port_arbiter #(.NREQ(N), .addr_wid_mem(AW), .data_wid(DW), .stroblen(SW),
                     .MAX_HOLD(MH)) dut (
    .aclk(aclk), .aresetn(aresetn), .req(req), .gnt(gnt),
    .r_addr(r_addr), .r_wdata(r_wdata), .r_wstrb(r_wstrb),
    .r_read(r_read), .r_write(r_write), .r_rvalid(r_rvalid), .r_rdata(r_rdata),
    .maddr(maddr), .mdata(mdata), .mwstrb(mwstrb), .mread(mread), .mwrite(mwrite),
    .sdata(sdata), .gclken(gclken), .proto_err(proto_err)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // reference model
  int            m_owner;
  bit            m_handoff;
  int            m_rr, m_hold, m_len, m_rd_id;
  bit            m_rd_pend;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] mem_ref[int];
  logic [DW-1:0] mem_dut[int];
  int            lens[$];
  int            owners[$];

  // stimulus plan per requester: kind 0=write 1=read 2=both 3=random 4=4 writes then reads
  int            left[N], start[N], kind[N], done[N];
  logic [AW-1:0] base[N];
  logic [DW-1:0] dbase[N];
  bit            noise;

  // observed port activity
  logic          ob_mwrite, ob_mread;
  logic [AW-1:0] ob_maddr;
  logic [DW-1:0] ob_mdata;
  logic [SW-1:0] ob_mwstrb;
  int            perr_seen, rv_seen;
  logic [DW-1:0] last_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return {6'h2A, a};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] res = old;
    for (int b = 0; b < SW; b++) if (strb[b]) res[8*b +: 8] = nw[8*b +: 8];
    return res;
  endfunction

  function automatic int q_get(input int q[$], input int k);
    return (q.size() > k) ? q[k] : -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_handoff = 0; m_rr = 0; m_hold = 0; m_len = 0;
    m_rd_pend = 0; m_rd_id = 0; m_rdata = '0;
  endtask

  function automatic bit all_done();
    bit d = (m_owner < 0) && !m_handoff && !m_rd_pend;
    for (int i = 0; i < N; i++) if (left[i] != 0) d = 0;
    return d;
  endfunction

  task automatic check_outputs();
    logic [N-1:0]  e_gnt = '0;
    logic [N-1:0]  e_rv;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_data = '0;
    logic [SW-1:0] e_strb = '0;
    logic          e_rd = 0, e_wr = 0, e_perr = 0, e_gclk;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      e_addr = r_addr[m_owner*AW +: AW];
      e_data = r_wdata[m_owner*DW +: DW];
      e_strb = r_wstrb[m_owner*SW +: SW];
      e_wr   = r_write[m_owner];
      e_rd   = r_read[m_owner] & ~r_write[m_owner];
      e_perr = r_read[m_owner] & r_write[m_owner];
    end
    e_rv   = m_rd_pend ? (3'b001 << m_rd_id) : 3'b000;
    e_gclk = (m_owner >= 0) || m_handoff || (|req);
    check("gnt", gnt, e_gnt);
    check("maddr", maddr, e_addr);
    check("mdata", mdata, e_data);
    check("mwstrb", mwstrb, e_strb);
    check("mwrite", mwrite, e_wr);
    check("mread", mread, e_rd);
    check("proto_err", proto_err, e_perr);
    check("r_rvalid", r_rvalid, e_rv);
    check("r_rdata", r_rdata, m_rd_pend ? m_rdata : '0);
    check("gclken", gclken, e_gclk);
    ob_mwrite = mwrite; ob_mread = mread; ob_maddr = maddr;
    ob_mdata = mdata; ob_mwstrb = mwstrb;
    if (proto_err) perr_seen++;
    if (r_rvalid != 0) begin rv_seen++; last_rdata = r_rdata; end
  endtask

  // Reference behaviour at a clock edge.
  task automatic model_step();
    int o = m_owner;
    logic rd = 0, wr = 0;
    logic [AW-1:0] a = '0;
    if (!aresetn) begin model_reset(); return; end
    if (o >= 0) begin
      rd = r_read[o]; wr = r_write[o]; a = r_addr[o*AW +: AW];
      if (wr) mem_ref[int'(a)] = merge(mem_ref.exists(int'(a)) ? mem_ref[int'(a)] : dflt(a),
                                        r_wdata[o*DW +: DW], r_wstrb[o*SW +: SW]);
    end
    m_rd_pend = (o >= 0) && rd && !wr;
    m_rd_id   = (o >= 0) ? o : 0;
    if (m_rd_pend) m_rdata = mem_ref.exists(int'(a)) ? mem_ref[int'(a)] : dflt(a);
    if (o >= 0) begin
      bit others = (req & ~(3'b001 << o)) != 0;
      if (rd || wr) m_len++;
      if (!req[o] || (m_hold == MH - 1 && others)) begin
        owners.push_back(o); lens.push_back(m_len);
        m_owner = -1; m_handoff = 1;
      end else if ((rd || wr) && m_hold < MH - 1) begin
        m_hold++;
      end
    end else if (req != 0) begin
      int w = -1;
      for (int k = 0; k < N; k++) if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
      m_owner = w; m_rr = (w + 1) % N; m_hold = 0; m_len = 0; m_handoff = 0;
    end else begin
      m_handoff = 0;
    end
  endtask

  task automatic cycle();
    logic [DW-1:0] nxt;
    @(negedge aclk);
    check_outputs();
    @(posedge aclk);
    model_step();
    nxt = $urandom;
    if (ob_mwrite)
      mem_dut[int'(ob_maddr)] = merge(mem_dut.exists(int'(ob_maddr)) ? mem_dut[int'(ob_maddr)]
                                      : dflt(ob_maddr), ob_mdata, ob_mwstrb);
    if (ob_mread) nxt = mem_dut.exists(int'(ob_maddr)) ? mem_dut[int'(ob_maddr)] : dflt(ob_maddr);
    #1 sdata = nxt;
  endtask

  task automatic setup_clear();
    for (int i = 0; i < N; i++) begin
      left[i] = 0; start[i] = 0; kind[i] = 0; done[i] = 0; base[i] = '0; dbase[i] = '0;
    end
    lens.delete(); owners.delete();
    perr_seen = 0; rv_seen = 0; last_rdata = '0;
  endtask

  task automatic quiet_inputs();
    req = '0; r_read = '0; r_write = '0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    quiet_inputs();
    model_reset();
    cycle();
    cycle();
    aresetn = 1'b1;
  endtask

  task automatic run_phase(input string name, input int budget, input bit must_finish);
    bit finished = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      int o;
      bit acc;
      if (all_done()) begin finished = 1; break; end
      r_read = '0; r_write = '0;
      if (noise) begin r_read = 3'($urandom); r_write = 3'($urandom); end
      for (int i = 0; i < N; i++) begin
        int idx = (kind[i] == 4) ? done[i] % 4 : done[i];
        req[i] = (cyc >= start[i]) && (left[i] > 0);
        r_addr[i*AW +: AW]  = base[i] + AW'(4 * idx);
        r_wdata[i*DW +: DW] = dbase[i] + DW'(idx);
        r_wstrb[i*SW +: SW] = noise ? 4'($urandom) : 4'hF;
      end
      o = m_owner;
      acc = 0;
      if (o >= 0) begin
        r_read[o] = 1'b0; r_write[o] = 1'b0;
        if (left[o] > 0) begin
          case (kind[o])
            0: r_write[o] = 1'b1;
            1: r_read[o] = 1'b1;
            2: begin r_read[o] = 1'b1; r_write[o] = 1'b1; end
            4: if (done[o] < 4) r_write[o] = 1'b1; else r_read[o] = 1'b1;
            default: {r_read[o], r_write[o]} = 2'($urandom_range(0, 3));
          endcase
          acc = r_read[o] | r_write[o];
        end
      end
      cycle();
      if (acc) begin left[o]--; done[o]++; end
    end
    if (!finished && all_done()) finished = 1;
    if (must_finish) check({name, "_completed"}, finished, 1'b1);
  endtask

  initial begin
    noise = 0;
    r_addr = '0; r_wdata = '0; r_wstrb = '0; sdata = '0;
    setup_clear();
    do_reset();

    // single requester 0: writes 0x100..0x10C then reads them back
    setup_clear();
    kind[0] = 4; left[0] = 8; base[0] = 26'h100; dbase[0] = 32'h1000_0000;
    run_phase("t_single", 100, 1);
    check("t_single_rvalids", rv_seen, 4);
    check("t_single_readback", last_rdata, 32'h1000_0003);
    check("t_single_grants", owners.size(), 1);
    check("t_single_len", q_get(lens, 0), 8);

    // simultaneous requests after reset: 0 first, then 1, then 0 again
    do_reset();
    setup_clear();
    left[0] = 2; left[1] = 2;
    run_phase("t_rr", 100, 1);
    check("t_rr_own0", q_get(owners, 0), 0);
    check("t_rr_own1", q_get(owners, 1), 1);
    setup_clear();
    kind[0] = 1; kind[1] = 1; left[0] = 1; left[1] = 1;
    run_phase("t_rr2", 100, 1);
    check("t_rr2_own0", q_get(owners, 0), 0);

    // forced rotation after MAX_HOLD accesses
    do_reset();
    setup_clear();
    kind[0] = 1; left[0] = 40; base[0] = 26'h400;
    kind[1] = 0; left[1] = 3;  base[1] = 26'h800;
    run_phase("t_preempt", 300, 1);
    check("t_preempt_grants", owners.size(), 3);
    check("t_preempt_len0", q_get(lens, 0), 16);
    check("t_preempt_own1", q_get(owners, 1), 1);
    check("t_preempt_own2", q_get(owners, 2), 0);
    check("t_preempt_len2", q_get(lens, 2), 24);

    // hold count saturates: 50 unopposed accesses, then a waiter preempts at once
    setup_clear();
    kind[0] = 1; left[0] = 60; base[0] = 26'h1000;
    kind[1] = 0; left[1] = 2;  start[1] = 50;
    run_phase("t_sat", 300, 1);
    check("t_sat_len0", q_get(lens, 0), 50);
    check("t_sat_own1", q_get(owners, 1), 1);
    check("t_sat_len2", q_get(lens, 2), 10);

    // read and write together: write performed, read dropped, error pulse
    setup_clear();
    kind[2] = 2; left[2] = 1; base[2] = 26'h20; dbase[2] = 32'hDEAD_BEEF;
    run_phase("t_proto", 50, 1);
    check("t_proto_pulses", perr_seen, 1);
    check("t_proto_no_rvalid", rv_seen, 0);
    setup_clear();
    kind[2] = 1; left[2] = 1; base[2] = 26'h20;
    run_phase("t_proto_rd", 50, 1);
    check("t_proto_readback", last_rdata, 32'hDEAD_BEEF);

    // reset in the middle of requester 1's read burst
    do_reset();
    setup_clear();
    kind[1] = 1; left[1] = 10; base[1] = 26'h200;
    run_phase("t_mid", 4, 0);
    check("t_mid_pre_gnt", gnt, 3'b010);
    check("t_mid_pre_rvalid", r_rvalid, 3'b010);
    #2 aresetn = 1'b0;
    #1;
    check("t_mid_gnt", gnt, 3'b000);
    check("t_mid_rvalid", r_rvalid, 3'b000);
    check("t_mid_mread", mread, 1'b0);
    model_reset();
    setup_clear();
    quiet_inputs();
    cycle();
    aresetn = 1'b1;
    left[1] = 1; left[2] = 1;
    run_phase("t_after", 100, 1);
    check("t_after_own0", q_get(owners, 0), 1);
    check("t_after_own1", q_get(owners, 1), 2);

    // randomized traffic with strobe noise from non-owners
    noise = 1;
    for (int round = 0; round < 6; round++) begin
      setup_clear();
      for (int i = 0; i < N; i++) begin
        kind[i]  = 3;
        left[i]  = $urandom_range(0, 25);
        start[i] = $urandom_range(0, 30);
        base[i]  = AW'($urandom_range(0, 63) * 4);
        dbase[i] = $urandom;
      end
      run_phase("t_rand", 3000, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
